// File: rtl/pwm_motor_ctrl_pkg.sv
// Shared types and default parameters for the multi-channel motor PWM block.
package pwm_pkg;

  typedef enum logic [1:0] {
    RUN,
    DECEL,
    DWELL
  } ch_state_e;

  localparam int unsigned CH_DEF            = 2;
  localparam int unsigned RES_DEF           = 7;
  localparam int unsigned RAMP_STEP_DEF     = 8;
  localparam int unsigned BRAKE_PERIODS_DEF = 4;

endpackage

// File: rtl/pwm_motor_ctrl_if.sv
// Setpoint/feedback bundle between the velocity controller and the PWM block.
interface pwm_motor_ctrl_if #(
  parameter int unsigned CH  = 2,
  parameter int unsigned RES = 7
);

  logic [CH*(RES+1)-1:0] setpt_in;
  logic [CH-1:0]         pwm_out;
  logic [CH-1:0]         dir_out;
  logic [CH-1:0]         at_setpt;

  modport master (
    output setpt_in,
    input  pwm_out,
    input  dir_out,
    input  at_setpt
  );

  modport slave (
    input  setpt_in,
    output pwm_out,
    output dir_out,
    output at_setpt
  );

endinterface

// File: rtl/pwm_motor_ctrl_channel.sv
// One PWM channel: boundary-latched sign-magnitude target, bounded duty ramp,
// and reversal sequenced through ramp-to-zero and a coast dwell.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int unsigned RES           = RES_DEF,
  parameter int unsigned RAMP_STEP     = RAMP_STEP_DEF,
  parameter int unsigned BRAKE_PERIODS = BRAKE_PERIODS_DEF
) (
  input  logic           clk_256k,
  input  logic           rst,
  input  logic [RES-1:0] cnt_i,
  input  logic           boundary_i,
  input  logic [RES:0]   setpt_i,
  output logic           pwm_o,
  output logic           dir_o,
  output logic           at_setpt_o
);

  localparam int unsigned  DMAX       = (1 << RES) - 1;
  localparam int unsigned  STEP_C     = (RAMP_STEP > DMAX) ? DMAX : RAMP_STEP;
  localparam logic [RES:0] STEP       = STEP_C[RES:0];
  localparam logic [RES:0] DMAX_W     = {1'b0, {RES{1'b1}}};
  localparam logic [7:0]   DWELL_INIT = BRAKE_PERIODS[7:0];

  ch_state_e      state_q, state_d;
  logic [RES-1:0] duty_q, duty_d;
  logic           dir_q, dir_d;
  logic [7:0]     dwell_q, dwell_d;
  logic           tgt_dir_q, tgt_dir_d;
  logic [RES-1:0] tgt_mag_q, tgt_mag_d;
  logic           pwm_q;

  logic           new_dir;
  logic [RES-1:0] new_mag;
  logic [RES:0]   duty_w, mag_w, diff_w, ramp_w, dec_w;
  logic           rev_req;

  always_comb begin
    new_dir = setpt_i[RES];
    new_mag = setpt_i[RES-1:0];
    duty_w  = {1'b0, duty_q};
    mag_w   = {1'b0, new_mag};

    // Ramp in RES+1 bits so duty+step cannot wrap; STEP == 0 means jump.
    if (mag_w > duty_w) begin
      diff_w = mag_w - duty_w;
      ramp_w = (STEP == '0 || diff_w <= STEP) ? mag_w : duty_w + STEP;
    end else begin
      diff_w = duty_w - mag_w;
      ramp_w = (STEP == '0 || diff_w <= STEP) ? mag_w : duty_w - STEP;
    end
    dec_w   = (STEP == '0 || duty_w <= STEP) ? '0 : duty_w - STEP;
    rev_req = (new_mag != '0) && (new_dir != dir_q);

    state_d   = state_q;
    duty_d    = duty_q;
    dir_d     = dir_q;
    dwell_d   = dwell_q;
    tgt_dir_d = tgt_dir_q;
    tgt_mag_d = tgt_mag_q;

    if (boundary_i) begin
      tgt_dir_d = new_dir;
      tgt_mag_d = new_mag;
      case (state_q)
        RUN: begin
          if (rev_req) begin
            if (duty_q == '0) begin
              state_d = DWELL;
              dwell_d = DWELL_INIT;
            end else begin
              state_d = DECEL;
            end
          end else begin
            duty_d = (ramp_w > DMAX_W) ? DMAX_W[RES-1:0] : ramp_w[RES-1:0];
          end
        end
        DECEL: begin
          if (!rev_req) begin
            state_d = RUN;
          end else begin
            duty_d = dec_w[RES-1:0];
            if (dec_w == '0) begin
              state_d = DWELL;
              dwell_d = DWELL_INIT;
            end
          end
        end
        DWELL: begin
          duty_d = '0;
          // The flip uses whatever target is latched on the final dwell boundary.
          if (dwell_q <= 8'd1) begin
            dwell_d = '0;
            state_d = RUN;
            if (new_mag != '0) begin
              dir_d = new_dir;
            end
          end else begin
            dwell_d = dwell_q - 8'd1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_256k or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      duty_q    <= '0;
      dir_q     <= 1'b0;
      dwell_q   <= '0;
      tgt_dir_q <= 1'b0;
      tgt_mag_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      duty_q    <= duty_d;
      dir_q     <= dir_d;
      dwell_q   <= dwell_d;
      tgt_dir_q <= tgt_dir_d;
      tgt_mag_q <= tgt_mag_d;
      pwm_q     <= (cnt_i < duty_q);
    end
  end

  assign pwm_o      = pwm_q;
  assign dir_o      = dir_q;
  assign at_setpt_o = (state_q == RUN) && (duty_q == tgt_mag_q) && (dir_q == tgt_dir_q);

endmodule

// File: rtl/pwm_motor_ctrl.sv
// Multi-channel motor PWM: shared period counter, period tick, half-rate clock,
// and one pwm_channel per motor.
module pwm_motor_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned CH            = CH_DEF,
  parameter int unsigned RES           = RES_DEF,
  parameter int unsigned RAMP_STEP     = RAMP_STEP_DEF,
  parameter int unsigned BRAKE_PERIODS = BRAKE_PERIODS_DEF
) (
  input  logic             clk_256k,
  input  logic             rst,
  pwm_motor_ctrl_if.slave  motor,
  output logic             period_tick,
  output logic             clk_half_out
);

  logic [RES-1:0] cnt_q, cnt_d;
  logic           boundary;
  logic           tick_q;
  logic [CH-1:0]  pwm_w, dir_w, at_w;

  assign cnt_d    = cnt_q + RES'(1);
  assign boundary = (cnt_q == '1);

  always_ff @(posedge clk_256k or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= boundary;
    end
  end

  assign period_tick  = tick_q;
  assign clk_half_out = cnt_q[RES-1];

  for (genvar c = 0; c < CH; c++) begin : g_ch
    pwm_channel #(
      .RES           (RES),
      .RAMP_STEP     (RAMP_STEP),
      .BRAKE_PERIODS (BRAKE_PERIODS)
    ) u_ch (
      .clk_256k   (clk_256k),
      .rst        (rst),
      .cnt_i      (cnt_q),
      .boundary_i (boundary),
      .setpt_i    (motor.setpt_in[c*(RES+1) +: (RES+1)]),
      .pwm_o      (pwm_w[c]),
      .dir_o      (dir_w[c]),
      .at_setpt_o (at_w[c])
    );
  end

  assign motor.pwm_out  = pwm_w;
  assign motor.dir_out  = dir_w;
  assign motor.at_setpt = at_w;

endmodule

// File: tb/tb_pwm_motor_ctrl.sv
// Scoreboard bench: per-period expected duty/dir/at_setpt queued at stimulus
// time, compared against PWM high counts measured over each period.
module tb_pwm_motor_ctrl;

  logic clk_256k = 1'b0;
  logic rst;
  logic a_tick, a_half, b_tick, b_half;

  always #5 clk_256k = ~clk_256k;

  pwm_motor_ctrl_if #(.CH(2), .RES(7)) ifa ();
  pwm_motor_ctrl_if #(.CH(2), .RES(7)) ifb ();

  pwm_motor_ctrl #(.CH(2), .RES(7), .RAMP_STEP(8), .BRAKE_PERIODS(4)) dut_a (
    .clk_256k     (clk_256k),
    .rst          (rst),
    .motor        (ifa),
    .period_tick  (a_tick),
    .clk_half_out (a_half)
  );

  pwm_motor_ctrl #(.CH(2), .RES(7), .RAMP_STEP(0), .BRAKE_PERIODS(4)) dut_b (
    .clk_256k     (clk_256k),
    .rst          (rst),
    .motor        (ifb),
    .period_tick  (b_tick),
    .clk_half_out (b_half)
  );

  typedef struct {
    int per;
    int dut;
    int ch;
    int duty;
    int dir;
    int at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cur      = -1;
  int   hi[2][2];
  int   dsnap[2][2];
  int   asnap[2][2];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pwm_bit(input int d, input int c);
    return (d == 0) ? int'(ifa.pwm_out[c]) : int'(ifb.pwm_out[c]);
  endfunction

  function automatic int dir_bit(input int d, input int c);
    return (d == 0) ? int'(ifa.dir_out[c]) : int'(ifb.dir_out[c]);
  endfunction

  function automatic int at_bit(input int d, input int c);
    return (d == 0) ? int'(ifa.at_setpt[c]) : int'(ifb.at_setpt[c]);
  endfunction

  // Monitor: close out the finished period on each tick, compare queued entries.
  always @(negedge clk_256k) begin
    if (a_tick === 1'b1) begin
      if (cur >= 0) begin
        while (sb.size() > 0 && sb[0].per <= cur) begin
          mon_e = sb.pop_front();
          check_eq($sformatf("p%0d_%s%0d_duty", mon_e.per, mon_e.dut ? "b" : "a", mon_e.ch),
                   hi[mon_e.dut][mon_e.ch], mon_e.duty);
          check_eq($sformatf("p%0d_%s%0d_dir", mon_e.per, mon_e.dut ? "b" : "a", mon_e.ch),
                   dsnap[mon_e.dut][mon_e.ch], mon_e.dir);
          check_eq($sformatf("p%0d_%s%0d_at", mon_e.per, mon_e.dut ? "b" : "a", mon_e.ch),
                   asnap[mon_e.dut][mon_e.ch], mon_e.at);
        end
      end
      cur++;
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < 2; c++) begin
          hi[d][c]    = pwm_bit(d, c);
          dsnap[d][c] = dir_bit(d, c);
          asnap[d][c] = at_bit(d, c);
        end
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < 2; c++) begin
          hi[d][c] += pwm_bit(d, c);
        end
      end
    end
  end

  task automatic push2(input int dut, input int per,
                       input int d0, input int r0, input int a0,
                       input int d1, input int r1, input int a1);
    exp_t e;
    e.per = per; e.dut = dut;
    e.ch = 0; e.duty = d0; e.dir = r0; e.at = a0;
    sb.push_back(e);
    e.ch = 1; e.duty = d1; e.dir = r1; e.at = a1;
    sb.push_back(e);
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    @(negedge clk_256k);
    while (a_tick !== 1'b1 && n < 400) begin
      @(negedge clk_256k);
      n++;
    end
    if (a_tick !== 1'b1) check_eq("tick_timeout", 0, 1);
    #1;
  endtask

  task automatic wait_until(input int n);
    int guard;
    guard = 0;
    while (cur < n && guard < 100) begin
      wait_tick();
      guard++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, q, r, t, k;
    rst = 1'b1;
    ifa.setpt_in = '0;
    ifb.setpt_in = '0;
    repeat (3) @(negedge clk_256k);
    #1;
    check_eq("rst_a_pwm", int'(ifa.pwm_out), 0);
    check_eq("rst_a_dir", int'(ifa.dir_out), 0);
    check_eq("rst_a_at", int'(ifa.at_setpt), 3);
    check_eq("rst_a_tick", int'(a_tick), 0);
    check_eq("rst_a_half", int'(a_half), 0);
    check_eq("rst_b_at", int'(ifb.at_setpt), 3);
    @(negedge clk_256k);
    rst = 1'b0;

    // Ramp 0 -> 0x20 in steps of 8
    wait_tick();
    p = cur;
    ifa.setpt_in = {8'h00, 8'h20};
    for (int i = 1; i <= 4; i++) push2(0, p + i, 8 * i, 0, (i == 4) ? 1 : 0, 0, 0, 1);
    repeat (64) @(negedge clk_256k);
    #1;
    check_eq("half_mid", int'(a_half), 1);
    check_eq("tick_mid", int'(a_tick), 0);
    wait_until(p + 4);

    // Ramp down to 0x10, then mid-period setpoint glitches that must not latch
    p = cur;
    ifa.setpt_in = {8'h00, 8'h10};
    push2(0, p + 1, 24, 0, 0, 0, 0, 1);
    push2(0, p + 2, 16, 0, 1, 0, 0, 1);
    wait_until(p + 2);
    p = cur;
    push2(0, p + 1, 16, 0, 1, 0, 0, 1);
    push2(0, p + 2, 16, 0, 1, 0, 0, 1);
    repeat (50) @(negedge clk_256k);
    ifa.setpt_in = {8'h00, 8'h40};
    repeat (50) @(negedge clk_256k);
    ifa.setpt_in = {8'h00, 8'h10};
    wait_until(p + 2);

    // Full reversal 0x40 -> 0xC0
    p = cur;
    ifa.setpt_in = {8'h00, 8'h40};
    for (int i = 1; i <= 6; i++) push2(0, p + i, 16 + 8 * i, 0, (i == 6) ? 1 : 0, 0, 0, 1);
    wait_until(p + 6);
    q = cur;
    ifa.setpt_in = {8'h00, 8'hC0};
    for (int i = 1; i <= 21; i++) begin
      if (i <= 8)       push2(0, q + i, 64 - 8 * (i - 1), 0, 0, 0, 0, 1);
      else if (i <= 12) push2(0, q + i, 0, 0, 0, 0, 0, 1);
      else if (i == 13) push2(0, q + i, 0, 1, 0, 0, 0, 1);
      else              push2(0, q + i, 8 * (i - 13), 1, (i == 21) ? 1 : 0, 0, 0, 1);
    end
    wait_until(q + 21);

    // Reversal request withdrawn at duty 24
    r = cur;
    ifa.setpt_in = {8'h00, 8'h40};
    for (int i = 1; i <= 6; i++) push2(0, r + i, 64 - 8 * (i - 1), 1, 0, 0, 0, 1);
    wait_until(r + 6);
    ifa.setpt_in = {8'h00, 8'hC0};
    for (int i = 7; i <= 12; i++) push2(0, r + i, 24 + 8 * (i - 7), 1, (i == 12) ? 1 : 0, 0, 0, 1);
    wait_until(r + 12);

    // No ramp limit: full-scale jump, zero magnitude keeps direction, one-step decel
    p = cur;
    ifb.setpt_in = {8'h80, 8'h7F};
    push2(1, p + 1, 127, 0, 1, 0, 0, 0);
    wait_until(p + 1);
    t = cur;
    ifb.setpt_in = {8'h80, 8'hFF};
    push2(1, t + 1, 127, 0, 0, 0, 0, 0);
    for (int i = 2; i <= 5; i++) push2(1, t + i, 0, 0, 0, 0, 0, 0);
    push2(1, t + 6, 0, 1, 0, 0, 0, 0);
    push2(1, t + 7, 127, 1, 1, 0, 0, 0);
    wait_until(t + 7);

    // Reset in mid-reversal / mid-dwell
    p = cur;
    ifa.setpt_in = {8'h88, 8'h08};
    push2(0, p + 1, 64, 1, 0, 0, 0, 0);
    wait_until(p + 2);
    repeat (40) @(negedge clk_256k);
    check_eq("pre_rst_a_dir", int'(ifa.dir_out), 1);
    check_eq("pre_rst_a_pwm", int'(ifa.pwm_out), 1);
    check_eq("pre_rst_a_at", int'(ifa.at_setpt), 0);
    check_eq("pre_rst_b_dir", int'(ifb.dir_out), 1);
    #3;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_a_pwm", int'(ifa.pwm_out), 0);
    check_eq("mid_rst_a_dir", int'(ifa.dir_out), 0);
    check_eq("mid_rst_a_at", int'(ifa.at_setpt), 3);
    check_eq("mid_rst_a_tick", int'(a_tick), 0);
    check_eq("mid_rst_a_half", int'(a_half), 0);
    check_eq("mid_rst_b_pwm", int'(ifb.pwm_out), 0);
    check_eq("mid_rst_b_dir", int'(ifb.dir_out), 0);
    ifa.setpt_in = {8'h88, 8'h20};
    repeat (5) @(negedge clk_256k);
    rst = 1'b0;

    wait_tick();
    k = cur;
    push2(0, k,     8,  0, 0, 0, 0, 0);
    push2(0, k + 1, 16, 0, 0, 0, 0, 0);
    push2(0, k + 2, 24, 0, 0, 0, 0, 0);
    push2(0, k + 3, 32, 0, 1, 0, 0, 0);
    push2(0, k + 4, 32, 0, 1, 0, 1, 0);
    push2(0, k + 5, 32, 0, 1, 8, 1, 1);
    wait_until(k + 6);

    check_eq("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
